// File: rtl/plab3_mem_prefetch_domain_arbiter_if.sv
// Memory-port bundle (request, response, found status, domain) shared by the requester
// ports and the prefetch-buffer port of plab3_mem_prefetch_domain_arbiter.
interface plab3_mem_prefetch_domain_arbiter_if #(
   parameter int unsigned p_opaque_nbits = 8,
   parameter int unsigned abw            = 32,
   parameter int unsigned dbw            = 32
);
   // Field layout: type(3) opaque addr len data / type(3) opaque test(2) len data
   localparam int unsigned req_nbits  = 3 + p_opaque_nbits + abw + $clog2(dbw/8) + dbw;
   localparam int unsigned resp_nbits = 3 + p_opaque_nbits + 2 + $clog2(dbw/8) + dbw;

   logic [req_nbits-1:0]  req_msg;
   logic                  req_val;
   logic                  req_rdy;
   logic [resp_nbits-1:0] resp_msg;
   logic                  resp_val;
   logic                  resp_rdy;
   logic [1:0]            found;
   logic                  domain;

   modport master (
      output req_msg, req_val, resp_rdy, domain,
      input  req_rdy, resp_msg, resp_val, found
   );

   modport slave (
      input  req_msg, req_val, resp_rdy, domain,
      output req_rdy, resp_msg, resp_val, found
   );
endinterface

// File: rtl/plab3_mem_prefetch_domain_arbiter.sv
// Two-domain arbiter in front of one plab3 prefetch buffer, one transaction outstanding.
// Define PLAB3_MEM_PFB_ARB_FIXED_SLOT_EN for time-division slots instead of round-robin.
module plab3_mem_prefetch_domain_arbiter #(
   parameter int unsigned p_opaque_nbits = 8,
   parameter int unsigned abw            = 32,
   parameter int unsigned dbw            = 32,
   parameter int unsigned p_slot_cycles  = 16
) (
   input logic clk,
   input logic reset,
   plab3_mem_prefetch_domain_arbiter_if.slave  req0,
   plab3_mem_prefetch_domain_arbiter_if.slave  req1,
   plab3_mem_prefetch_domain_arbiter_if.master pfb
);
   localparam int unsigned req_nbits = 3 + p_opaque_nbits + abw + $clog2(dbw/8) + dbw;

   localparam logic [1:0] STATE_IDLE  = 2'd0;
   localparam logic [1:0] STATE_ISSUE = 2'd1;
   localparam logic [1:0] STATE_WAIT  = 2'd2;

   logic [1:0]           state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 ptr_q, ptr_d;
   logic [req_nbits-1:0] req_reg_q, req_reg_d;

   logic grant;
   logic grant_ok;

`ifdef PLAB3_MEM_PFB_ARB_FIXED_SLOT_EN
   localparam int unsigned cnt_nbits = (p_slot_cycles > 2) ? $clog2(p_slot_cycles) : 1;
   localparam logic [cnt_nbits-1:0] cnt_last = cnt_nbits'(p_slot_cycles - 1);

   logic [cnt_nbits-1:0] slot_cnt_q, slot_cnt_d;
   logic                 slot_owner_q, slot_owner_d;

   // Counter parks on its last value while busy, so a slot never ends mid-transaction.
   always_comb begin
      slot_cnt_d   = slot_cnt_q;
      slot_owner_d = slot_owner_q;
      if (slot_cnt_q != cnt_last) begin
         slot_cnt_d = slot_cnt_q + 1'b1;
      end else if (state_q == STATE_IDLE) begin
         slot_cnt_d   = '0;
         slot_owner_d = ~slot_owner_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_cnt_q   <= '0;
         slot_owner_q <= 1'b0;
      end else begin
         slot_cnt_q   <= slot_cnt_d;
         slot_owner_q <= slot_owner_d;
      end
   end

   // Last cycle of a slot cannot accept: the issue would spill into the next slot.
   assign grant    = slot_owner_q;
   assign grant_ok = (slot_cnt_q != cnt_last);
`else
   assign grant    = (req0.req_val && req1.req_val) ? ptr_q : req1.req_val;
   assign grant_ok = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      req_reg_d = req_reg_q;

      req0.req_rdy  = 1'b0;
      req1.req_rdy  = 1'b0;
      req0.resp_val = 1'b0;
      req1.resp_val = 1'b0;
      req0.resp_msg = '0;
      req1.resp_msg = '0;
      req0.found    = 2'b00;
      req1.found    = 2'b00;
      pfb.req_val   = 1'b0;
      pfb.resp_rdy  = 1'b0;
      pfb.req_msg   = req_reg_q;
      pfb.domain    = owner_q;

      unique case (state_q)
         STATE_IDLE: begin
            if (reset && grant_ok) begin
               req0.req_rdy = ~grant;
               req1.req_rdy = grant;
               if (grant ? req1.req_val : req0.req_val) begin
                  req_reg_d = grant ? req1.req_msg : req0.req_msg;
                  owner_d   = grant;
                  state_d   = STATE_ISSUE;
               end
            end
         end
         STATE_ISSUE: begin
            pfb.req_val = 1'b1;
            if (pfb.req_rdy) state_d = STATE_WAIT;
         end
         STATE_WAIT: begin
            // Non-owner sees an all-zero response so nothing leaks across domains.
            if (owner_q) begin
               req1.resp_val = pfb.resp_val;
               req1.resp_msg = pfb.resp_msg;
               req1.found    = pfb.found;
               pfb.resp_rdy  = req1.resp_rdy;
            end else begin
               req0.resp_val = pfb.resp_val;
               req0.resp_msg = pfb.resp_msg;
               req0.found    = pfb.found;
               pfb.resp_rdy  = req0.resp_rdy;
            end
            if (pfb.resp_val && pfb.resp_rdy) begin
               ptr_d   = ~owner_q;
               state_d = STATE_IDLE;
            end
         end
         default: state_d = STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= STATE_IDLE;
         owner_q   <= 1'b0;
         ptr_q     <= 1'b0;
         req_reg_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         req_reg_q <= req_reg_d;
      end
   end
endmodule

// File: tb/tb_plab3_mem_prefetch_domain_arbiter.sv
// Directed bench for plab3_mem_prefetch_domain_arbiter; the slot scenario runs when
// PLAB3_MEM_PFB_ARB_FIXED_SLOT_EN is defined, the round-robin scenarios otherwise.
module tb_plab3_mem_prefetch_domain_arbiter;
   localparam int unsigned o   = 8;
   localparam int unsigned abw = 32;
   localparam int unsigned dbw = 32;
`ifdef PLAB3_MEM_PFB_ARB_FIXED_SLOT_EN
   localparam int unsigned slot_cycles = 4;
`else
   localparam int unsigned slot_cycles = 16;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   plab3_mem_prefetch_domain_arbiter_if #(.p_opaque_nbits(o), .abw(abw), .dbw(dbw)) req0_if ();
   plab3_mem_prefetch_domain_arbiter_if #(.p_opaque_nbits(o), .abw(abw), .dbw(dbw)) req1_if ();
   plab3_mem_prefetch_domain_arbiter_if #(.p_opaque_nbits(o), .abw(abw), .dbw(dbw)) pfb_if ();

   plab3_mem_prefetch_domain_arbiter #(
      .p_opaque_nbits (o),
      .abw            (abw),
      .dbw            (dbw),
      .p_slot_cycles  (slot_cycles)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req0  (req0_if.slave),
      .req1  (req1_if.slave),
      .pfb   (pfb_if.master)
   );

   // 77-bit request: type, opaque, addr, len, data; 47-bit response: type, opaque, test, len, data
   logic [76:0] msg0   = {3'd0, 8'h01, 32'h0000_0100, 2'd0, 32'h0000_0000};
   logic [76:0] msg1   = {3'd1, 8'h22, 32'h0000_0200, 2'd0, 32'hdead_beef};
   logic [46:0] resp_a = {3'd0, 8'h01, 2'd0, 2'd0, 32'h1234_5678};

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction with both requesters' valids as given; exp_port must win.
   task automatic serve(input logic v0, input logic v1, input int exp_port, input string tag);
      logic [76:0] em;
      logic [46:0] er;
      logic [1:0]  ef;
      em = (exp_port == 1) ? msg1 : msg0;
      er = resp_a ^ 47'(exp_port + 1);
      ef = (exp_port == 1) ? 2'b01 : 2'b10;
      req0_if.req_msg = msg0;
      req1_if.req_msg = msg1;
      req0_if.req_val = v0;
      req1_if.req_val = v1;
      #1;
      check_eq({tag, ".rdy0"}, req0_if.req_rdy, exp_port == 0);
      check_eq({tag, ".rdy1"}, req1_if.req_rdy, exp_port == 1);
      step();
      req0_if.req_val = 1'b0;
      req1_if.req_val = 1'b0;
      #1;
      check_eq({tag, ".pfb_req_val"}, pfb_if.req_val, 1'b1);
      check_eq({tag, ".pfb_domain"}, pfb_if.domain, exp_port[0]);
      check_eq({tag, ".pfb_req_msg"}, pfb_if.req_msg, em);
      check_eq({tag, ".busy_rdy"}, {req0_if.req_rdy, req1_if.req_rdy}, 2'b00);
      pfb_if.req_rdy = 1'b1;
      step();
      pfb_if.req_rdy  = 1'b0;
      pfb_if.resp_msg = er;
      pfb_if.resp_val = 1'b1;
      pfb_if.found    = ef;
      req0_if.resp_rdy = 1'b1;
      req1_if.resp_rdy = 1'b1;
      #1;
      check_eq({tag, ".wait_req_val"}, pfb_if.req_val, 1'b0);
      check_eq({tag, ".resp_vals"}, {req1_if.resp_val, req0_if.resp_val},
               (exp_port == 1) ? 2'b10 : 2'b01);
      check_eq({tag, ".resp_msg"}, (exp_port == 1) ? req1_if.resp_msg : req0_if.resp_msg, er);
      check_eq({tag, ".found"}, {req1_if.found, req0_if.found},
               (exp_port == 1) ? {ef, 2'b00} : {2'b00, ef});
      check_eq({tag, ".pfb_resp_rdy"}, pfb_if.resp_rdy, 1'b1);
      step();
      pfb_if.resp_val = 1'b0;
      pfb_if.found    = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      req0_if.req_msg = '0;  req0_if.req_val = 1'b0;  req0_if.resp_rdy = 1'b0;
      req0_if.domain  = 1'b0;
      req1_if.req_msg = '0;  req1_if.req_val = 1'b0;  req1_if.resp_rdy = 1'b0;
      req1_if.domain  = 1'b1;
      pfb_if.req_rdy  = 1'b0;  pfb_if.resp_msg = '0;  pfb_if.resp_val = 1'b0;
      pfb_if.found    = 2'b00;

      #2;
      check_eq("rst.rdy", {req0_if.req_rdy, req1_if.req_rdy}, 2'b00);
      check_eq("rst.pfb_req_val", pfb_if.req_val, 1'b0);
      check_eq("rst.pfb_domain", pfb_if.domain, 1'b0);
      check_eq("rst.resp_vals", {req0_if.resp_val, req1_if.resp_val}, 2'b00);
      step();
      step();
      reset = 1'b1;
      #1;

`ifdef PLAB3_MEM_PFB_ARB_FIXED_SLOT_EN
      // Slot 0 spans counter 0..3; port 1 must wait for slot 1, counter 0.
      req1_if.req_msg = msg1;
      req1_if.req_val = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t6.slot0_rdy1_c%0d", i), req1_if.req_rdy, 1'b0);
         step();
      end
      check_eq("t6.slot1_rdy1", req1_if.req_rdy, 1'b1);
      check_eq("t6.slot1_rdy0", req0_if.req_rdy, 1'b0);
      step();
      req1_if.req_val = 1'b0;
      check_eq("t6.pfb_req_val", pfb_if.req_val, 1'b1);
      check_eq("t6.pfb_domain", pfb_if.domain, 1'b1);
      check_eq("t6.pfb_req_msg", pfb_if.req_msg, msg1);
`else
      check_eq("idle.rdy", {req0_if.req_rdy, req1_if.req_rdy}, 2'b10);

      serve(1'b1, 1'b0, 0, "t1");
      serve(1'b1, 1'b1, 1, "t2_ptr");

      // Port 1 alone wins; buffer stalls the request for three cycles.
      req1_if.req_msg = msg1;
      req1_if.req_val = 1'b1;
      #1;
      check_eq("t3.rdy1", req1_if.req_rdy, 1'b1);
      step();
      req1_if.req_val = 1'b0;
      req0_if.req_msg = msg0;
      req0_if.req_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq($sformatf("t3.hold_val%0d", i), pfb_if.req_val, 1'b1);
         check_eq($sformatf("t3.hold_msg%0d", i), pfb_if.req_msg, msg1);
         check_eq($sformatf("t3.hold_dom%0d", i), pfb_if.domain, 1'b1);
         check_eq($sformatf("t3.hold_rdy%0d", i), {req0_if.req_rdy, req1_if.req_rdy}, 2'b00);
         step();
      end
      pfb_if.req_rdy = 1'b1;
      step();
      pfb_if.req_rdy  = 1'b0;
      req0_if.req_val = 1'b0;

      // Owner withholds response ready for two cycles.
      pfb_if.resp_msg  = resp_a;
      pfb_if.resp_val  = 1'b1;
      pfb_if.found     = 2'b01;
      req0_if.resp_rdy = 1'b1;
      req1_if.resp_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_eq($sformatf("t4.resp_rdy%0d", i), pfb_if.resp_rdy, 1'b0);
         check_eq($sformatf("t4.resp_val%0d", i), {req1_if.resp_val, req0_if.resp_val}, 2'b10);
         check_eq($sformatf("t4.found%0d", i), {req1_if.found, req0_if.found}, 4'b0100);
         step();
      end
      req1_if.resp_rdy = 1'b1;
      #1;
      check_eq("t4.resp_rdy_go", pfb_if.resp_rdy, 1'b1);
      step();
      pfb_if.resp_val = 1'b0;
      pfb_if.found    = 2'b00;
      #1;
      check_eq("t4.idle_rdy", {req0_if.req_rdy, req1_if.req_rdy}, 2'b10);

      // Reset asserted while port 1's transaction waits for its response.
      req1_if.req_val = 1'b1;
      step();
      req1_if.req_val = 1'b0;
      pfb_if.req_rdy  = 1'b1;
      step();
      pfb_if.req_rdy   = 1'b0;
      pfb_if.resp_val  = 1'b1;
      pfb_if.found     = 2'b11;
      req1_if.resp_rdy = 1'b0;
      #1;
      check_eq("t5.pre_resp_val1", req1_if.resp_val, 1'b1);
      reset = 1'b0;
      #1;
      check_eq("t5.resp_vals", {req1_if.resp_val, req0_if.resp_val}, 2'b00);
      check_eq("t5.found", {req1_if.found, req0_if.found}, 4'b0000);
      check_eq("t5.pfb_domain", pfb_if.domain, 1'b0);
      check_eq("t5.pfb_req_val", pfb_if.req_val, 1'b0);
      check_eq("t5.pfb_resp_rdy", pfb_if.resp_rdy, 1'b0);
      check_eq("t5.rdy", {req0_if.req_rdy, req1_if.req_rdy}, 2'b00);
      pfb_if.resp_val = 1'b0;
      pfb_if.found    = 2'b00;
      step();
      reset = 1'b1;

      serve(1'b1, 1'b1, 0, "t5_after");
      serve(1'b1, 1'b1, 1, "t2_second");
      serve(1'b1, 1'b1, 0, "t2_repeat");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
